// File: rtl/conv_req_arbiter.sv
// Round-robin front end sharing one 8x8-tap convolution engine between two requesters (watchdog: CONV_ARB_TIMEOUT_EN).
// Latency: ack one cycle after grant; each engine result beat is re-registered with one cycle of delay.
// Backpressure: requests stay pending while a job is in flight; LOAD holds until the engine reports idle.
module conv_req_arbiter #(
    parameter int IN_LEN  = 8,
    parameter int OUT_LEN = 15
`ifdef CONV_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req0,
    input  logic [8*IN_LEN-1:0]           data0,
    output logic                          ack0,
    input  logic                          req1,
    input  logic [8*IN_LEN-1:0]           data1,
    output logic                          ack1,
    input  logic                          eng_busy,
    input  logic                          eng_out_valid,
    input  logic [7:0]                    eng_dout,
    output logic                          eng_in_en,
    output logic [3:0]                    eng_din,
    output logic                          res_valid,
    output logic                          res_id,
    output logic [$clog2(OUT_LEN)-1:0]    res_idx,
    output logic [7:0]                    res_data,
    output logic                          res_last,
    output logic                          active,
    output logic                          err
);
    localparam int FEED_LEN = 2 * IN_LEN;
    localparam int FCW      = $clog2(FEED_LEN);
    localparam int OCW      = $clog2(OUT_LEN);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FEED, S_WAIT_OUT, S_COLLECT} state_t;

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  owner_q, owner_d;
    logic [8*IN_LEN-1:0]   data_q, data_d;
    logic [FCW-1:0]        feed_cnt_q, feed_cnt_d;
    logic [OCW-1:0]        out_cnt_q, out_cnt_d;
    logic                  ack0_q, ack0_d, ack1_q, ack1_d;
    logic                  res_valid_q, res_valid_d, res_id_q, res_id_d, res_last_q, res_last_d;
    logic [OCW-1:0]        res_idx_q, res_idx_d;
    logic [7:0]            res_data_q, res_data_d;
    logic                  grant_1;

    // Requester 1 wins when alone, or on a tie when requester 0 was served last.
    assign grant_1 = req1 & (~req0 | ~last_grant_q);

`ifdef CONV_ARB_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDW-1:0] wd_q, wd_d;
    logic           err_q, wd_run, wd_fire;

    assign wd_run  = (state_q == S_LOAD) || (state_q == S_WAIT_OUT);
    assign wd_fire = wd_run && (wd_q == WDW'(TIMEOUT_CYCLES - 1));
    assign wd_d    = (!wd_run || (state_d != state_q)) ? '0 : wd_q + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= wd_fire;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        data_d       = data_q;
        feed_cnt_d   = feed_cnt_q;
        out_cnt_d    = out_cnt_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        res_valid_d  = 1'b0;
        res_id_d     = 1'b0;
        res_idx_d    = '0;
        res_data_d   = '0;
        res_last_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    data_d       = grant_1 ? data1 : data0;
                    owner_d      = grant_1;
                    last_grant_d = grant_1;
                    ack0_d       = ~grant_1;
                    ack1_d       = grant_1;
                    state_d      = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!eng_busy) begin
                    feed_cnt_d = '0;
                    state_d    = S_FEED;
                end
            end
            S_FEED: begin
                feed_cnt_d = feed_cnt_q + 1'b1;
                if (feed_cnt_q == FCW'(FEED_LEN - 1)) begin
                    feed_cnt_d = '0;
                    out_cnt_d  = '0;
                    state_d    = S_WAIT_OUT;
                end
            end
            S_WAIT_OUT, S_COLLECT: begin
                // out_cnt is zero on entry to WAIT_OUT, so the first beat lands at index 0.
                if (eng_out_valid) begin
                    res_valid_d = 1'b1;
                    res_id_d    = owner_q;
                    res_idx_d   = out_cnt_q;
                    res_data_d  = eng_dout;
                    if (out_cnt_q == OCW'(OUT_LEN - 1)) begin
                        res_last_d = 1'b1;
                        out_cnt_d  = '0;
                        state_d    = S_IDLE;
                    end else begin
                        out_cnt_d  = out_cnt_q + 1'b1;
                        state_d    = S_COLLECT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef CONV_ARB_TIMEOUT_EN
        // Abandon the job; last_grant is left alone so the other side wins the next tie.
        if (wd_fire) begin
            state_d     = S_IDLE;
            feed_cnt_d  = '0;
            out_cnt_d   = '0;
            res_valid_d = 1'b0;
            res_id_d    = 1'b0;
            res_idx_d   = '0;
            res_data_d  = '0;
            res_last_d  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            data_q       <= '0;
            feed_cnt_q   <= '0;
            out_cnt_q    <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            res_valid_q  <= 1'b0;
            res_id_q     <= 1'b0;
            res_idx_q    <= '0;
            res_data_q   <= '0;
            res_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            data_q       <= data_d;
            feed_cnt_q   <= feed_cnt_d;
            out_cnt_q    <= out_cnt_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            res_valid_q  <= res_valid_d;
            res_id_q     <= res_id_d;
            res_idx_q    <= res_idx_d;
            res_data_q   <= res_data_d;
            res_last_q   <= res_last_d;
        end
    end

    // f and g are packed back to back, so stream position n is simply nibble n of the word.
    assign eng_in_en = (state_q == S_FEED);
    assign eng_din   = eng_in_en ? data_q[{feed_cnt_q, 2'b00} +: 4] : 4'd0;
    assign active    = (state_q != S_IDLE);
    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_idx   = res_idx_q;
    assign res_data  = res_data_q;
    assign res_last  = res_last_q;
endmodule

// File: tb/tb_conv_req_arbiter.sv
// Directed bench for conv_req_arbiter with a behavioural 8x8-tap convolution engine on the far side.
module tb_conv_req_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [63:0] data0 = '0, data1 = '0;
    logic        ack0, ack1;
    logic        eng_busy = 1'b0, eng_out_valid = 1'b0;
    logic [7:0]  eng_dout = '0;
    logic        eng_in_en;
    logic [3:0]  eng_din;
    logic        res_valid, res_id, res_last, active, err;
    logic [3:0]  res_idx;
    logic [7:0]  res_data;
    logic [23:0] all_out;

    int total = 0;
    int bad = 0;

    localparam logic [63:0] D_ONES   = 64'h1111_1111_1111_1111;
    localparam logic [63:0] D_SPARSE = 64'h0000_0003_0000_0002;
    int exp_ones [15] = '{1, 2, 3, 4, 5, 6, 7, 8, 7, 6, 5, 4, 3, 2, 1};

    always #5 clk = ~clk;

    conv_req_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .data0(data0), .ack0(ack0),
        .req1(req1), .data1(data1), .ack1(ack1),
        .eng_busy(eng_busy), .eng_out_valid(eng_out_valid), .eng_dout(eng_dout),
        .eng_in_en(eng_in_en), .eng_din(eng_din),
        .res_valid(res_valid), .res_id(res_id), .res_idx(res_idx), .res_data(res_data),
        .res_last(res_last), .active(active), .err(err)
    );

    assign all_out = {ack0, ack1, eng_in_en, eng_din, res_valid, res_id, res_idx, res_data,
                      res_last, active, err};

    // Engine model: gathers 16 nibbles, then emits 15 convolution beats after a short delay.
    bit         eng_mute = 1'b0;
    logic [3:0] e_buf [16];
    int         e_cnt = 0, e_delay = 0, e_k = -1;

    function automatic logic [7:0] conv_at(input int k);
        int s = 0;
        for (int i = 0; i < 8; i++)
            if (k - i >= 0 && k - i < 8) s += int'(e_buf[i]) * int'(e_buf[8 + k - i]);
        return 8'(s);
    endfunction

    always @(negedge clk) begin
        eng_out_valid = 1'b0;
        eng_dout      = 8'd0;
        if (reset) begin
            e_cnt = 0; e_delay = 0; e_k = -1; eng_busy = 1'b0;
        end else begin
            if (e_k >= 0) begin
                eng_out_valid = 1'b1;
                eng_dout      = conv_at(e_k);
                e_k++;
                if (e_k == 15) begin e_k = -1; eng_busy = 1'b0; end
            end else if (e_delay > 0) begin
                e_delay--;
                if (e_delay == 0) e_k = 0;
            end
            if (eng_in_en === 1'b1) begin
                e_buf[e_cnt] = eng_din;
                e_cnt++;
                if (e_cnt == 16) begin
                    e_cnt = 0;
                    if (!eng_mute) begin eng_busy = 1'b1; e_delay = 3; end
                end
            end
        end
    end

    // Monitor: logs beats, acks, res_last, err and end-of-stream with a shared cycle stamp.
    int          cyc = 0;
    bit          prev_en = 1'b0;
    logic [13:0] beats [$];
    int          ack_id [$], ack_cyc [$], last_cyc [$], err_cyc [$], fall_cyc [$];

    always @(negedge clk) begin
        cyc++;
        if (res_valid === 1'b1) beats.push_back({res_id, res_idx, res_data, res_last});
        if (res_last === 1'b1) last_cyc.push_back(cyc);
        if (ack0 === 1'b1) begin ack_id.push_back(0); ack_cyc.push_back(cyc); end
        if (ack1 === 1'b1) begin ack_id.push_back(1); ack_cyc.push_back(cyc); end
        if (err === 1'b1) err_cyc.push_back(cyc);
        if (prev_en && eng_in_en !== 1'b1) fall_cyc.push_back(cyc);
        prev_en = (eng_in_en === 1'b1);
    end

    function automatic logic [13:0] exp_beat(input bit id, input bit sparse, input int k);
        int v;
        if (sparse) v = (k == 0) ? 6 : 0;
        else        v = exp_ones[k];
        return {id, 4'(k), 8'(v), (k == 14)};
    endfunction

    function automatic logic [3:0] exp_nib(input bit sparse, input int k);
        if (!sparse) return 4'd1;
        return (k == 0) ? 4'd2 : (k == 8) ? 4'd3 : 4'd0;
    endfunction

    function automatic logic [13:0] got_beat(input int i);
        return (i < beats.size()) ? beats[i] : 14'bx;
    endfunction

    task automatic clear_logs();
        beats.delete(); ack_id.delete(); ack_cyc.delete();
        last_cyc.delete(); err_cyc.delete(); fall_cyc.delete();
    endtask

    task automatic wait_ack(input bit who, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            ok = ((who ? ack1 : ack0) === 1'b1);
        end
    endtask

    task automatic wait_feed(input int budget, output bit ok);
        ok = (eng_in_en === 1'b1);
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            ok = (eng_in_en === 1'b1);
        end
    endtask

    task automatic wait_beats(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk); #1;
            ok = (beats.size() >= n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (all_out !== 24'd0) begin
            bad++; $display("FAIL reset_outputs: got %h required 000000", all_out);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (all_out !== 24'd0) begin
            bad++; $display("FAIL idle_no_req: got %h required 000000", all_out);
        end
    endtask

    task automatic test_single_req(input bit who);
        bit ok, okf, okb;
        int feed_err;
        clear_logs();
        if (who) begin data1 = D_SPARSE; req1 = 1'b1; end
        else     begin data0 = D_ONES;   req0 = 1'b1; end
        wait_ack(who, 20, ok);
        req0 = 1'b0; req1 = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL single%0d_ack: no ack within 20 cycles, required one", who); end
        @(negedge clk);
        total++;
        if ({ack0, ack1, active} !== 3'b001) begin
            bad++; $display("FAIL single%0d_ack_pulse: ack0/ack1/active=%b required 001", who, {ack0, ack1, active});
        end
        wait_feed(10, okf);
        feed_err = 0;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            if (eng_in_en !== 1'b1 || eng_din !== exp_nib(who, k)) feed_err++;
        end
        @(negedge clk);
        total++;
        if (!okf || feed_err != 0 || eng_in_en !== 1'b0 || eng_din !== 4'd0) begin
            bad++; $display("FAIL single%0d_feed: started=%b bad_nibbles=%0d en/din after=%b/%h required 1,0,0/0",
                            who, okf, feed_err, eng_in_en, eng_din);
        end
        wait_beats(15, 60, okb);
        for (int i = 0; i < 15; i++) begin
            total++;
            if (got_beat(i) !== exp_beat(who, who, i)) begin
                bad++; $display("FAIL single%0d_beat%0d: got %h required %h", who, i, got_beat(i), exp_beat(who, who, i));
            end
        end
        repeat (3) @(negedge clk); #1;
        total++;
        if (!okb || beats.size() != 15 || ack_id.size() != 1 || active !== 1'b0) begin
            bad++; $display("FAIL single%0d_count: beats=%0d acks=%0d active=%b required 15,1,0",
                            who, beats.size(), ack_id.size(), active);
        end
    endtask

    task automatic test_tie();
        bit ok0, ok1, okb;
        int gap;
        reset = 1'b1; repeat (2) @(negedge clk); reset = 1'b0; @(negedge clk);
        clear_logs();
        data0 = D_ONES; data1 = D_SPARSE; req0 = 1'b1; req1 = 1'b1;
        wait_ack(1'b0, 20, ok0);
        req0 = 1'b0;
        total++;
        if (!ok0 || ack1 !== 1'b0) begin
            bad++; $display("FAIL tie_first: ack0_seen=%b ack1=%b required 1,0", ok0, ack1);
        end
        wait_ack(1'b1, 120, ok1);
        req1 = 1'b0;
        wait_beats(30, 80, okb);
        gap = (ack_cyc.size() >= 2 && last_cyc.size() >= 1) ? ack_cyc[1] - last_cyc[0] : -1;
        total++;
        if (!ok1 || !okb || ack_id.size() != 2 || gap != 1) begin
            bad++; $display("FAIL tie_regrant: ack1_seen=%b beats_done=%b acks=%0d ack1-res_last gap=%0d required 1,1,2,1",
                            ok1, okb, ack_id.size(), gap);
        end
        for (int i = 0; i < 30; i++) begin
            total++;
            if (got_beat(i) !== exp_beat(i >= 15, i >= 15, i % 15)) begin
                bad++; $display("FAIL tie_beat%0d: got %h required %h", i, got_beat(i), exp_beat(i >= 15, i >= 15, i % 15));
            end
        end
    endtask

    task automatic test_back_to_back();
        bit okb;
        clear_logs();
        data0 = D_ONES; data1 = D_SPARSE; req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 400 && ack_id.size() < 4; i++) begin @(negedge clk); #1; end
        req0 = 1'b0; req1 = 1'b0;
        wait_beats(60, 100, okb);
        repeat (5) @(negedge clk); #1;
        total++;
        if (!okb || ack_id.size() != 4 || last_cyc.size() != 4) begin
            bad++; $display("FAIL b2b_counts: beats_done=%b acks=%0d lasts=%0d required 1,4,4", okb, ack_id.size(), last_cyc.size());
        end
        for (int k = 0; k < 4 && k < ack_id.size(); k++) begin
            total++;
            if (ack_id[k] != k % 2) begin
                bad++; $display("FAIL b2b_grant%0d: got requester %0d required %0d", k, ack_id[k], k % 2);
            end
        end
        for (int k = 1; k < 4 && k < ack_cyc.size() && k <= last_cyc.size(); k++) begin
            total++;
            if (ack_cyc[k] != last_cyc[k-1] + 1) begin
                bad++; $display("FAIL b2b_ack_timing%0d: ack at cycle %0d, previous res_last at %0d, required res_last+1",
                                k, ack_cyc[k], last_cyc[k-1]);
            end
        end
        for (int i = 0; i < 60; i++) begin
            total++;
            if (got_beat(i) !== exp_beat((i / 15) % 2, (i / 15) % 2, i % 15)) begin
                bad++; $display("FAIL b2b_beat%0d: got %h required %h", i, got_beat(i), exp_beat((i / 15) % 2, (i / 15) % 2, i % 15));
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok, okf;
        clear_logs();
        data0 = D_ONES; req0 = 1'b1;
        wait_ack(1'b0, 20, ok);
        req0 = 1'b0;
        wait_feed(10, okf);
        repeat (7) @(negedge clk);
        total++;
        if (!ok || !okf || eng_in_en !== 1'b1 || eng_din !== 4'd1) begin
            bad++; $display("FAIL rstmid_setup: ack=%b feed=%b en=%b din=%h required 1,1,1,1", ok, okf, eng_in_en, eng_din);
        end
        reset = 1'b1; #1;
        total++;
        if (all_out !== 24'd0) begin
            bad++; $display("FAIL rstmid_outputs: got %h required 000000", all_out);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk); #1;
        total++;
        if (ack_id.size() != 1 || beats.size() != 0 || active !== 1'b0) begin
            bad++; $display("FAIL rstmid_job_lost: acks=%0d beats=%0d active=%b required 1,0,0", ack_id.size(), beats.size(), active);
        end
        test_single_req(1'b0);
    endtask

`ifdef CONV_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int dist;
        clear_logs();
        eng_mute = 1'b1; data0 = D_ONES; req0 = 1'b1;
        wait_ack(1'b0, 20, ok);
        req0 = 1'b0;
        for (int i = 0; i < 200 && err_cyc.size() == 0; i++) begin @(negedge clk); #1; end
        dist = (err_cyc.size() >= 1 && fall_cyc.size() >= 1) ? err_cyc[0] - fall_cyc[0] : -1;
        total++;
        if (!ok || dist != 64) begin
            bad++; $display("FAIL timeout_delay: ack=%b err after %0d cycles in WAIT_OUT, required 64", ok, dist);
        end
        total++;
        if (active !== 1'b0 || beats.size() != 0) begin
            bad++; $display("FAIL timeout_idle: active=%b beats=%0d required 0,0", active, beats.size());
        end
        @(negedge clk);
        total++;
        if (err !== 1'b0 || err_cyc.size() != 1) begin
            bad++; $display("FAIL timeout_pulse: err=%b pulses=%0d required 0,1", err, err_cyc.size());
        end
        eng_mute = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_req(1'b0);
        test_single_req(1'b1);
        test_tie();
        test_back_to_back();
        test_reset_mid();
`ifdef CONV_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_watchdog: run exceeded 300000 time units, required completion");
        $fatal(1, "bench stalled");
    end
endmodule
